// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MUL/DIV engine for the Execute stage, one result bit per cycle.
// Build option: define MULDIV_DIV_EN to include the restoring divider (DIVU/REMU).
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      count_reg;
    logic [1:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic               busy_reg, done_reg, dbz_reg;
    logic               accept, last_step;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   step_result;
`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   rem_reg, rem_next, quo_next;
    logic [WIDTH:0]     shifted, diff;
    logic               borrow;
`endif

    assign accept    = (state_reg == IDLE) && start && !flush;
    assign last_step = (count_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    stall = 1'b1;
`ifdef MULDIV_DIV_EN
                    state_next = RUN;
`else
                    state_next = op[1] ? DONE : RUN;
`endif
                end
            end
            RUN: begin
                stall = 1'b1;
                if (flush)          state_next = IDLE;
                else if (last_step) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift-add: low half starts as the multiplier and drains out while the product fills in.
    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_reg} : '0);
        mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        shifted  = {rem_reg, acc_reg[WIDTH-1]};
        diff     = shifted - {1'b0, b_reg};
        // With a nonzero divisor the remainder stays below it, so bit WIDTH of diff is the borrow.
        borrow   = diff[WIDTH];
        rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_next = {acc_reg[WIDTH-2:0], ~borrow};
        acc_next = op_reg[1] ? {acc_reg[2*WIDTH-1:WIDTH], quo_next} : mul_next;
        case (op_reg)
            2'b00:   step_result = mul_next[WIDTH-1:0];
            2'b01:   step_result = mul_next[2*WIDTH-1:WIDTH];
            2'b10:   step_result = (b_reg == '0) ? '1 : quo_next;
            default: step_result = (b_reg == '0) ? a_reg : rem_next;
        endcase
`else
        acc_next = mul_next;
        case (op_reg)
            2'b01:   step_result = mul_next[2*WIDTH-1:WIDTH];
            default: step_result = mul_next[WIDTH-1:0];
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= '0;
            op_reg     <= '0;
            a_reg      <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            dbz_reg    <= 1'b0;
`ifdef MULDIV_DIV_EN
            b_reg      <= '0;
            rem_reg    <= '0;
`endif
        end else begin
            busy_reg <= (state_next == RUN);
            done_reg <= (state_next == DONE);
            dbz_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg    <= op;
                        a_reg     <= src_a;
                        count_reg <= '0;
`ifdef MULDIV_DIV_EN
                        b_reg     <= src_b;
                        rem_reg   <= '0;
                        acc_reg   <= op[1] ? {{WIDTH{1'b0}}, src_a} : {{WIDTH{1'b0}}, src_b};
`else
                        acc_reg   <= {{WIDTH{1'b0}}, src_b};
                        if (op[1]) result_reg <= '0;
`endif
                    end
                end
                RUN: begin
                    count_reg <= count_reg + 1'b1;
                    acc_reg   <= acc_next;
`ifdef MULDIV_DIV_EN
                    rem_reg   <= rem_next;
`endif
                    if (!flush && last_step) begin
                        result_reg <= step_result;
`ifdef MULDIV_DIV_EN
                        dbz_reg    <= op_reg[1] && (b_reg == '0);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign result      = result_reg;
    assign div_by_zero = dbz_reg;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus randomized traffic vs. a behavioural model.
module tb_muldiv_sequencer;
    localparam int W = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk, rst, start, flush;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         stall, busy, done, div_by_zero;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result),
        .div_by_zero(div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (o)
            2'd0:    return prod[W-1:0];
            2'd1:    return prod[2*W-1:W];
            2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Behavioural model: an accepted op completes W+1 edges later unless flushed or reset.
    bit           model_on = 0;
    bit           m_busy = 0, m_done = 0, m_dbz = 0, p_dbz = 0;
    logic [W-1:0] m_result = '0, p_result = '0;
    int           m_left = 0;

    always @(negedge clk) begin
        if (model_on) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("result", result, m_result);
            chk("div_by_zero", div_by_zero, m_dbz);
            chk("stall", stall, m_busy | (!m_busy && !m_done && start && !flush));
            if (done)
                $display("txn done: result=%h div_by_zero=%0b at %0t", result, div_by_zero, $time);
        end
        if (rst) begin
            model_on = 1;
            m_busy = 0; m_done = 0; m_dbz = 0; m_result = '0;
        end else if (m_busy) begin
            if (flush) m_busy = 0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1; m_result = p_result; m_dbz = p_dbz;
                end
            end
        end else if (m_done) begin
            m_done = 0; m_dbz = 0;
        end else if (start && !flush) begin
            if (!DIV_EN && op[1]) begin
                m_done = 1; m_result = '0; m_dbz = 0;
            end else begin
                p_result = ref_result(op, src_a, src_b);
                p_dbz    = op[1] && (src_b == 0);
                m_busy   = 1;
                m_left   = W;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input bit exp_dbz, input bit hold);
        int lat;
        int exp_lat;
        exp_lat = W + 1;
        if (!DIV_EN && o[1]) begin
            exp_lat = 1; exp_res = '0; exp_dbz = 0;
        end
        start = 1'b1; op = o; src_a = a; src_b = b;
        step();
        lat = 1;
        if (!hold) start = 1'b0;
        src_a = $urandom; src_b = $urandom; op = 2'($urandom);
        while (!done && lat < W + 10) begin
            step();
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, exp_lat);
        chk("op_result", result, exp_res);
        chk("op_dbz", div_by_zero, exp_dbz);
        chk("busy_at_done", busy, 1'b0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
        step(); step();
        rst = 1'b0;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, '0);
        chk("reset_dbz", div_by_zero, 1'b0);

        run_op(2'd0, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0);
        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        run_op(2'd2, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        run_op(2'd3, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
        run_op(2'd2, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op(2'd3, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0);

        // Flush at cycle 10 of a MULLO: nothing completes and the old result survives.
        run_op(2'd0, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0);
        start = 1'b1; op = 2'd0; src_a = $urandom; src_b = $urandom;
        step();
        start = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_done", done, 1'b0);
        chk("flush_result", result, 32'd42);
        repeat (W + 3) step();
        chk("flush_result_held", result, 32'd42);
        run_op(2'd0, 32'd3, 32'd3, 32'd9, 1'b0, 1'b0);

        // Reset at cycle 20 of a DIVU.
        run_op(2'd0, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0);
        start = 1'b1; op = 2'd2; src_a = 32'd100; src_b = 32'd7;
        step();
        start = 1'b0;
        repeat (19) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_result", result, '0);
        chk("rst_done", done, 1'b0);
        repeat (3) step();

        run_op(2'd0, 32'd12345, 32'd678, 32'd8369910, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 4) == 0;
            flush = ($urandom % 32) == 0;
            rst   = ($urandom % 700) == 0;
            op    = 2'($urandom);
            src_a = (($urandom % 4) == 0) ? W'($urandom % 256) : W'($urandom);
            src_b = (($urandom % 8) == 0) ? '0 :
                    (($urandom % 4) == 0) ? W'($urandom % 16) : W'($urandom);
            step();
        end
        start = 1'b0; flush = 1'b0; rst = 1'b0;
        repeat (W + 4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
